uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver.
- Consumes the 16x-oversample receive baud clock produced by the baud rate generator and the asynchronous serial input line.
- Delivers received bytes to the bus interface through a ready/ack handshake, with framing and overrun status.
- Sits between the baud rate generator and the UART register interface of the console device.

Parameters:
DATA_BITS, 8, number of data bits per frame, LSB first
OVERSAMPLE, 16, rx_baud_clk rising edges per bit time
CNT_W, 4, sample-counter width; must satisfy CNT_W >= log2(OVERSAMPLE)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_baud_clk  input  1  16x-baud square wave from the baud generator; synchronous to clk
rxd  input  1  serial line, idle high, asynchronous
rx_data  output  DATA_BITS  last received byte
rx_ready  output  1  byte available in rx_data
rx_ack  input  1  one-clk pulse from the consumer; clears rx_ready and both error flags
framing_err  output  1  last frame had stop bit = 0 (sticky until ack)
overrun_err  output  1  a frame completed while rx_ready was still 1 (sticky until ack)
rx_busy  output  1  receiver not in IDLE

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - rx_data = 0; rx_ready, framing_err, overrun_err and rx_busy = 0.
  - State = IDLE; counters = 0; shift register = 0.
  - Synchroniser flops = 1; previous-baud register = 0.
- rxd passes through a 2-flop synchroniser (rxd_s) before any use.
- tick: one-clk pulse when rx_baud_clk = 1 and the registered previous value = 0. All state advances happen only on tick; the handshake logic runs every clk.
- IDLE:
  - On tick with rxd_s = 0, go to START with cnt = 0.
- START:
  - On each tick, cnt++.
  - On the tick where cnt = OVERSAMPLE/2-1 (the 8th tick after detection), re-check rxd_s.
  - rxd_s = 0: go to DATA with cnt = 0 and bit_idx = 0.
  - rxd_s = 1 (glitch): return to IDLE; no status change.
- DATA:
  - On each tick, cnt++.
  - On the tick where cnt = OVERSAMPLE-1: shift rxd_s into the MSB of the shift register (right shift, so the byte ends up LSB-first), set cnt = 0, bit_idx++.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - On the tick where cnt = OVERSAMPLE-1, sample rxd_s.
  - Always load rx_data from the shift register and set rx_ready = 1.
  - framing_err is set if the stop sample = 0; otherwise it is unchanged.
  - overrun_err is set if rx_ready was already 1 and rx_ack is not asserted in that clk.
  - New data always overwrites rx_data.
  - Return to IDLE.
  - A stop bit of 0 (line break) repeats the start detection on the next tick; a continuous break therefore yields repeated framing errors with rx_data = 0.
- Latency: rx_ready rises on the clk edge that registers the stop-sample tick. This is ~9.5 bit times after the start edge, plus up to 1 tick of detection skew and 2 clk of synchroniser delay.
- Handshake:
  - rx_ack in a clk with no frame completion clears rx_ready, framing_err and overrun_err on the next edge.
  - rx_ack in the same clk as a frame completion: completion wins. rx_ready stays 1, the new data is loaded, overrun is not set, and framing_err reflects the new frame only.
  - rx_ack while rx_ready = 0 is a no-op.
- rx_busy = (state != IDLE), registered with the state.
- Reset mid-frame aborts immediately to the reset values. The next falling edge after reset release starts a fresh frame.

Test Plan:
- Frame 0x55 at 9600 baud (rx_baud_clk from the generator at 20 MHz) -> rx_ready = 1, rx_data = 0x55, framing_err = 0, overrun_err = 0. After an rx_ack pulse, rx_ready = 0 on the next clk.
- Start glitch: rxd low for 4 ticks, then high -> state back to IDLE, rx_busy = 0, rx_ready stays 0.
- Frame 0xA3 with stop bit driven 0 -> rx_data = 0xA3, rx_ready = 1, framing_err = 1. After rx_ack, both flags are 0.
- Frames 0x12 then 0x34 with no ack -> rx_data = 0x34, rx_ready = 1, overrun_err = 1. rx_ack clears all three.
- rx_ack asserted in the exact clk of the second frame's completion -> rx_ready = 1, rx_data = second byte, overrun_err = 0.
- Reset asserted during data bit 3, released, then frame 0xC9 sent -> all outputs 0 during reset; afterwards rx_data = 0xC9 with no errors.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x-oversampled start detection, mid-bit sampling,
// and a ready/ack handshake carrying sticky framing and overrun status.
`timescale 1ns/1ps
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_baud_clk,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    input  logic                 rx_ack,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic                 rxd_m, rxd_s;
    logic                 baud_q, tick;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIT_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 done;

    assign tick = rx_baud_clk & ~baud_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_m       <= 1'b1;
            rxd_s       <= 1'b1;
            baud_q      <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_busy     <= 1'b0;
            rx_data     <= '0;
            rx_ready    <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rxd_m   <= rxd;
            rxd_s   <= rxd_m;
            baud_q  <= rx_baud_clk;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            rx_busy <= (state_n != IDLE);
            // A completing frame takes priority over a coincident ack.
            if (done) begin
                rx_data     <= shreg;
                rx_ready    <= 1'b1;
                framing_err <= ~rxd_s | (framing_err & ~rx_ack);
                overrun_err <= (rx_ready | overrun_err) & ~rx_ack;
            end else if (rx_ack) begin
                rx_ready    <= 1'b0;
                framing_err <= 1'b0;
                overrun_err <= 1'b0;
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        done      = 1'b0;
        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt_n     = '0;
                        bit_idx_n = '0;
                        state_n   = rxd_s ? IDLE : DATA;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        shreg_n   = {rxd_s, shreg[DATA_BITS-1:1]};
                        cnt_n     = '0;
                        bit_idx_n = bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST) state_n = STOP;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        done    = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames, glitch, framing, overrun,
// ack/completion collision and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    bit         rx_baud_clk = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rx_ack = 1'b0;
    logic       framing_err;
    logic       overrun_err;
    logic       rx_busy;

    int n_cmp = 0;
    int n_err = 0;
    int half_div = 2;
    int bcnt = 0;
    int n_cal = 0;
    bit abort = 1'b0;

    uart_rx dut (
        .clk         (clk),
        .reset       (reset),
        .rx_baud_clk (rx_baud_clk),
        .rxd         (rxd),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_ack      (rx_ack),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .rx_busy     (rx_busy)
    );

    always #25 clk = ~clk;

    always @(posedge clk) begin
        if (bcnt >= half_div - 1) begin
            bcnt        <= 0;
            rx_baud_clk <= ~rx_baud_clk;
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] d, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rxd = fr[b];
            for (int t = 0; t < 16; t++) begin
                @(posedge rx_baud_clk);
                if (abort) begin
                    rxd = 1'b1;
                    return;
                end
            end
        end
        rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        @(posedge rx_baud_clk);
        send_bits(d, stop_bit);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge rx_baud_clk);
        #1;
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
    endtask

    initial begin
        #(50 * 90000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("rst_data", rx_data, 0);
        check("rst_ready", rx_ready, 0);
        check("rst_ferr", framing_err, 0);
        check("rst_oerr", overrun_err, 0);
        check("rst_busy", rx_busy, 0);
        reset = 1'b0;

        // ~9600 baud from a 20 MHz clock: 130 clk per 16x tick
        half_div = 65;
        wait_ticks(2);
        send_frame(8'h55, 1'b1);
        wait_ticks(4);
        check("f55_ready", rx_ready, 1);
        check("f55_data", rx_data, 8'h55);
        check("f55_ferr", framing_err, 0);
        check("f55_oerr", overrun_err, 0);
        pulse_ack();
        check("f55_ack_ready", rx_ready, 0);

        half_div = 2;
        wait_ticks(4);

        @(posedge rx_baud_clk);
        rxd = 1'b0;
        repeat (4) @(posedge rx_baud_clk);
        #1;
        check("glitch_busy_mid", rx_busy, 1);
        rxd = 1'b1;
        wait_ticks(16);
        check("glitch_busy", rx_busy, 0);
        check("glitch_ready", rx_ready, 0);

        send_frame(8'hA3, 1'b0);
        wait_ticks(20);
        check("fa3_data", rx_data, 8'hA3);
        check("fa3_ready", rx_ready, 1);
        check("fa3_ferr", framing_err, 1);
        check("fa3_oerr", overrun_err, 0);
        pulse_ack();
        check("fa3_ack_ready", rx_ready, 0);
        check("fa3_ack_ferr", framing_err, 0);
        wait_ticks(4);

        // first frame also measures clk count from start edge to ready
        @(posedge rx_baud_clk);
        fork
            send_bits(8'h12, 1'b1);
            begin
                n_cal = 0;
                while (!rx_ready && n_cal < 4000) begin
                    @(posedge clk);
                    #1;
                    n_cal++;
                end
            end
        join
        check("f12_ready", rx_ready, 1);
        check("f12_data", rx_data, 8'h12);
        send_frame(8'h34, 1'b1);
        wait_ticks(4);
        check("ovr_data", rx_data, 8'h34);
        check("ovr_ready", rx_ready, 1);
        check("ovr_oerr", overrun_err, 1);
        pulse_ack();
        check("ovr_ack_ready", rx_ready, 0);
        check("ovr_ack_ferr", framing_err, 0);
        check("ovr_ack_oerr", overrun_err, 0);

        send_frame(8'h5A, 1'b1);
        wait_ticks(2);
        check("f5a_ready", rx_ready, 1);
        @(posedge rx_baud_clk);
        fork
            send_bits(8'h6B, 1'b1);
            begin
                if (n_cal > 1) repeat (n_cal - 1) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
            end
        join
        wait_ticks(2);
        check("coll_ready", rx_ready, 1);
        check("coll_data", rx_data, 8'h6B);
        check("coll_oerr", overrun_err, 0);
        check("coll_ferr", framing_err, 0);

        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (16 * 4 + 8) @(posedge rx_baud_clk);
                #1;
                check("mid_busy", rx_busy, 1);
                reset = 1'b1;
                abort = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                check("mid_rst_data", rx_data, 0);
                check("mid_rst_ready", rx_ready, 0);
                check("mid_rst_ferr", framing_err, 0);
                check("mid_rst_oerr", overrun_err, 0);
                check("mid_rst_busy", rx_busy, 0);
            end
        join
        reset = 1'b0;
        abort = 1'b0;
        wait_ticks(4);
        send_frame(8'hC9, 1'b1);
        wait_ticks(4);
        check("fc9_data", rx_data, 8'hC9);
        check("fc9_ready", rx_ready, 1);
        check("fc9_ferr", framing_err, 0);
        check("fc9_oerr", overrun_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
